// File: rtl/instruction_fetch_controller_pkg.sv
// rtl/instruction_fetch_controller_pkg.sv - shared widths, opcodes and fetch state encodings
package instruction_fetch_controller_pkg;

    localparam int ADDR_W    = 8;
    localparam int INSTR_W   = 8;
    localparam int MEM_DEPTH = 255;

    localparam logic [ADDR_W-1:0] RESET_PC    = 8'h00;
    localparam logic [ADDR_W-1:0] MEM_LAST    = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [2:0]        HALT_OPCODE = 3'b111;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return (pc == MEM_LAST) ? '0 : pc + 1'b1;
    endfunction

endpackage

// File: rtl/instruction_fetch_controller_pc_reg.sv
// rtl/instruction_fetch_controller_pc_reg.sv - program counter with load, wrapping increment and hold
module instruction_fetch_controller_pc_reg
    import instruction_fetch_controller_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_pc,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= next_pc(r_pc);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - PC sequencing, instruction slot, redirect/halt/fault control
module instruction_fetch_controller
    import instruction_fetch_controller_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    output logic [ADDR_W-1:0]  o_imem_address,
    input  logic [INSTR_W-1:0] i_imem_instruction,
    output logic [INSTR_W-1:0] o_instr_out,
    output logic [ADDR_W-1:0]  o_pc_out,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_target,
    output logic               o_halted,
    output logic               o_addr_fault
);

    fetch_state_t       r_state;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc_out;
    logic               r_valid;
    logic               r_halted;
    logic               r_fault;

    logic               w_run;
    logic               w_start_ok;
    logic               w_bad_target;
    logic               w_slot_free;
    logic               w_halt_accept;
    logic               w_pc_load;
    logic               w_pc_inc;
    logic [ADDR_W-1:0]  w_pc;
    logic [ADDR_W-1:0]  w_load_pc;

    assign w_run         = (r_state == FS_RUN);
    assign w_start_ok    = i_start && !w_run;
    assign w_bad_target  = i_redirect_target > MEM_LAST;
    assign w_slot_free   = !r_valid || i_instr_ready;
    assign w_halt_accept = r_valid && i_instr_ready && (r_instr[7:5] == HALT_OPCODE);

    // A faulting redirect leaves the PC where it was; only legal targets load.
    assign w_pc_load = w_start_ok || (w_run && i_redirect && !w_bad_target);
    assign w_load_pc = w_start_ok ? RESET_PC : i_redirect_target;
    assign w_pc_inc  = w_run && !i_redirect && !w_halt_accept && w_slot_free;

    instruction_fetch_controller_pc_reg u_pc_reg (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_load    (w_pc_load),
        .i_load_pc (w_load_pc),
        .i_inc     (w_pc_inc),
        .o_pc      (w_pc)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= FS_IDLE;
            r_instr  <= '0;
            r_pc_out <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                FS_IDLE, FS_HALT: begin
                    if (i_start) begin
                        r_state  <= FS_RUN;
                        r_valid  <= 1'b0;
                        r_halted <= 1'b0;
                        r_fault  <= 1'b0;
                    end
                end
                FS_RUN: begin
                    // Redirect wins over everything, including a HALT instruction waiting in the slot.
                    if (i_redirect) begin
                        r_valid <= 1'b0;
                        if (w_bad_target) begin
                            r_fault  <= 1'b1;
                            r_halted <= 1'b1;
                            r_state  <= FS_HALT;
                        end
                    end else if (w_halt_accept) begin
                        r_valid  <= 1'b0;
                        r_halted <= 1'b1;
                        r_state  <= FS_HALT;
                    end else if (w_slot_free) begin
                        r_instr  <= i_imem_instruction;
                        r_pc_out <= w_pc;
                        r_valid  <= 1'b1;
                    end
                end
                default: r_state <= FS_IDLE;
            endcase
        end
    end

    assign o_imem_address = w_pc;
    assign o_instr_out    = r_instr;
    assign o_pc_out       = r_pc_out;
    assign o_instr_valid  = r_valid;
    assign o_halted       = r_halted;
    assign o_addr_fault   = r_fault;

endmodule
